projectile_engine: RTL and testbench

Projectile pool manager on the consumer side of the spaceship controller: accepts fire requests tagged with the ship's 4-bit heading, spawns projectiles at the ship origin, and advances them once per video frame. Projectiles leaving the visible area are retired. Outputs per-slot position/active state feed the renderer and collision logic.

---
 rtl/projectile_engine_pkg.sv | 61 ++++++
 rtl/projectile_engine_slot.sv | 94 +++++++++
 rtl/projectile_engine.sv | 102 ++++++++++
 tb/tb_projectile_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/projectile_engine_pkg.sv
// Shared constants, types and the heading-to-direction table for the projectile engine.
package projectile_engine_pkg;

    localparam int POS_W = 11;
    localparam int VEL_W = 8;

    typedef logic signed [VEL_W-1:0] vel_t;

    typedef enum logic {
        IDLE,
        FLYING
    } slot_state_e;

    // Cosine-like component for 16 headings, 0 = +x, counter-clockwise.
    function automatic vel_t dir_c(input logic [3:0] k);
        int v;
        case (k)
            4'd0:    v = 4;
            4'd1:    v = 4;
            4'd2:    v = 3;
            4'd3:    v = 2;
            4'd4:    v = 0;
            4'd5:    v = -2;
            4'd6:    v = -3;
            4'd7:    v = -4;
            4'd8:    v = -4;
            4'd9:    v = -4;
            4'd10:   v = -3;
            4'd11:   v = -2;
            4'd12:   v = 0;
            4'd13:   v = 2;
            4'd14:   v = 3;
            default: v = 4;
        endcase
        return vel_t'(v);
    endfunction

    function automatic vel_t dir_s(input logic [3:0] k);
        int v;
        case (k)
            4'd0:    v = 0;
            4'd1:    v = 2;
            4'd2:    v = 3;
            4'd3:    v = 4;
            4'd4:    v = 4;
            4'd5:    v = 4;
            4'd6:    v = 3;
            4'd7:    v = 2;
            4'd8:    v = 0;
            4'd9:    v = -2;
            4'd10:   v = -3;
            4'd11:   v = -4;
            4'd12:   v = -4;
            4'd13:   v = -4;
            4'd14:   v = -3;
            default: v = -2;
        endcase
        return vel_t'(v);
    endfunction

endpackage

// File: rtl/projectile_engine_slot.sv
// One projectile slot: IDLE/FLYING state, position and velocity registers, bounds check.
module projectile_slot
    import projectile_engine_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ORIGIN_X = 320,
    parameter int ORIGIN_Y = 240
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             spawn_i,
    input  logic             tick_i,
    input  logic [VEL_W-1:0] vx_i,
    input  logic [VEL_W-1:0] vy_i,
    output logic             active_o,
    output logic [POS_W-1:0] x_o,
    output logic [POS_W-1:0] y_o,
    output logic             expire_o
);

    localparam logic signed [POS_W-1:0] X_MAX = POS_W'(SCREEN_W - 1);
    localparam logic signed [POS_W-1:0] Y_MAX = POS_W'(SCREEN_H - 1);

    slot_state_e state_q, state_d;

    logic signed [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [POS_W-1:0] nx, ny;
    logic [VEL_W-1:0]        vx_q, vx_d, vy_q, vy_d;
    logic                    oob;

    always_comb begin
        nx  = x_q + {{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
        ny  = y_q + {{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
        oob = nx[POS_W-1] || (nx > X_MAX) || ny[POS_W-1] || (ny > Y_MAX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (spawn_i) state_d = FLYING;
            FLYING:  if (tick_i && oob) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active_o = (state_q == FLYING);
        expire_o = (state_q == FLYING) && tick_i && oob;
    end

    // A spawn takes priority so a slot spawned on a tick edge stays at the origin.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        vx_d = vx_q;
        vy_d = vy_q;
        if (spawn_i) begin
            x_d  = POS_W'(ORIGIN_X);
            y_d  = POS_W'(ORIGIN_Y);
            vx_d = vx_i;
            vy_d = vy_i;
        end else if ((state_q == FLYING) && tick_i) begin
            x_d = nx;
            y_d = ny;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q  <= '0;
            y_q  <= '0;
            vx_q <= '0;
            vy_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            vx_q <= vx_d;
            vy_q <= vy_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/projectile_engine.sv
// Projectile pool: fire allocation to the lowest idle slot, fire cooldown, spawn/expire pulses.
module projectile_engine
    import projectile_engine_pkg::*;
#(
    parameter int MAX_PROJ = 4,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ORIGIN_X = 320,
    parameter int ORIGIN_Y = 240,
    parameter int SPEED    = 1,
    parameter int COOLDOWN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      fire_valid,
    input  logic [3:0]                angle,
    output logic                      fire_ready,
    output logic [MAX_PROJ-1:0]       proj_active,
    output logic [MAX_PROJ*POS_W-1:0] proj_x,
    output logic [MAX_PROJ*POS_W-1:0] proj_y,
    output logic                      spawn_pulse,
    output logic                      expire_pulse
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [CD_W-1:0]     cooldown_q, cooldown_d;
    logic                spawn_q, spawn_d;
    logic                expire_q, expire_d;
    logic                accept;
    logic                found;
    logic [MAX_PROJ-1:0] spawn_sel;
    logic [MAX_PROJ-1:0] expire_vec;
    vel_t                vx, vy;

    always_comb begin
        fire_ready = !reset && (cooldown_q == '0) && !(&proj_active);
        accept     = fire_valid && fire_ready;
        vx         = dir_c(angle) * vel_t'(SPEED);
        vy         = -(dir_s(angle) * vel_t'(SPEED));
    end

    always_comb begin
        spawn_sel = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < MAX_PROJ; i++) begin
            if (!proj_active[i] && !found) begin
                spawn_sel[i] = accept;
                found        = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < MAX_PROJ; g++) begin : g_slot
        projectile_slot #(
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H),
            .ORIGIN_X (ORIGIN_X),
            .ORIGIN_Y (ORIGIN_Y)
        ) u_slot (
            .clk_i    (clk),
            .rst_i    (reset),
            .spawn_i  (spawn_sel[g]),
            .tick_i   (frame_tick),
            .vx_i     (vx),
            .vy_i     (vy),
            .active_o (proj_active[g]),
            .x_o      (proj_x[g*POS_W +: POS_W]),
            .y_o      (proj_y[g*POS_W +: POS_W]),
            .expire_o (expire_vec[g])
        );
    end

    // An accept reloads the cooldown even on a tick edge.
    always_comb begin
        cooldown_d = cooldown_q;
        if (accept) begin
            cooldown_d = CD_W'(COOLDOWN);
        end else if (frame_tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end
        spawn_d  = accept;
        expire_d = |expire_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cooldown_q <= '0;
            spawn_q    <= 1'b0;
            expire_q   <= 1'b0;
        end else begin
            cooldown_q <= cooldown_d;
            spawn_q    <= spawn_d;
            expire_q   <= expire_d;
        end
    end

    assign spawn_pulse  = spawn_q;
    assign expire_pulse = expire_q;

endmodule

// File: tb/tb_projectile_engine.sv
// Directed bench: default engine (COOLDOWN=4) and a COOLDOWN=0 engine, checked with immediate assertions.
module tb_projectile_engine;

    logic        clk;
    logic        reset;
    logic        ft, fv;
    logic [3:0]  ang;
    logic        rdy, sp, ex;
    logic [3:0]  act;
    logic [43:0] px, py;
    logic        ft0, fv0;
    logic [3:0]  ang0;
    logic        rdy0, sp0, ex0;
    logic [3:0]  act0;
    logic [43:0] px0, py0;

    int n_checks = 0;
    int n_fail   = 0;

    projectile_engine dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (ft),
        .fire_valid   (fv),
        .angle        (ang),
        .fire_ready   (rdy),
        .proj_active  (act),
        .proj_x       (px),
        .proj_y       (py),
        .spawn_pulse  (sp),
        .expire_pulse (ex)
    );

    projectile_engine #(.COOLDOWN(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (ft0),
        .fire_valid   (fv0),
        .angle        (ang0),
        .fire_ready   (rdy0),
        .proj_active  (act0),
        .proj_x       (px0),
        .proj_y       (py0),
        .spawn_pulse  (sp0),
        .expire_pulse (ex0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [10:0] sl(input logic [43:0] v, input int i);
        return v[i*11 +: 11];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        ft = 1'b1;
        step();
        ft = 1'b0;
        step();
    endtask

    task automatic tick0();
        ft0 = 1'b1;
        step();
        ft0 = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        ft = 1'b0; fv = 1'b0; ang = 4'd0;
        ft0 = 1'b0; fv0 = 1'b0; ang0 = 4'd0;
        step();
        step();
        chk("rst_ready", rdy, 0);
        chk("rst_active", act, 0);
        chk("rst_x", px, 0);
        chk("rst_y", py, 0);
        chk("rst_spawn", sp, 0);
        reset = 1'b0;
        #1;
        chk("release_ready", rdy, 1);

        // Fire at angle 0; hold the request and move angle to 4 for the next accept.
        fv = 1'b1; ang = 4'd2;
        #1 ang = 4'd0;
        step();
        ang = 4'd4;
        chk("acc0_active", act, 4'b0001);
        chk("acc0_x", sl(px, 0), 320);
        chk("acc0_y", sl(py, 0), 240);
        chk("acc0_spawn", sp, 1);
        chk("acc0_ready", rdy, 0);
        step();
        chk("acc0_spawn_clr", sp, 0);
        chk("cd_hold_active", act, 4'b0001);
        tick();
        tick();
        tick();
        chk("t3_x", sl(px, 0), 332);
        chk("t3_y", sl(py, 0), 240);
        chk("t3_active", act, 4'b0001);
        chk("t3_ready", rdy, 0);
        ft = 1'b1;
        step();
        ft = 1'b0;
        chk("t4_ready", rdy, 1);
        chk("t4_x", sl(px, 0), 336);
        chk("t4_active", act, 4'b0001);
        step();
        fv = 1'b0;
        chk("acc1_active", act, 4'b0011);
        chk("acc1_x", sl(px, 1), 320);
        chk("acc1_y", sl(py, 1), 240);
        chk("acc1_spawn", sp, 1);
        chk("acc1_x0", sl(px, 0), 336);

        repeat (60) tick();
        chk("t60_y1", sl(py, 1), 0);
        chk("t60_x1", sl(px, 1), 320);
        chk("t60_active", act, 4'b0011);
        chk("t60_x0", sl(px, 0), 576);
        chk("t60_expire", ex, 0);
        ft = 1'b1;
        step();
        ft = 1'b0;
        chk("t61_y1", sl(py, 1), 11'h7FC);
        chk("t61_active", act, 4'b0001);
        chk("t61_expire", ex, 1);
        chk("t61_x0", sl(px, 0), 580);
        step();
        chk("t61_expire_clr", ex, 0);
        chk("t61_y1_kept", sl(py, 1), 11'h7FC);

        // Accept coincident with a frame tick.
        fv = 1'b1; ang = 4'd0; ft = 1'b1;
        step();
        fv = 1'b0; ft = 1'b0;
        chk("co_active", act, 4'b0011);
        chk("co_x1", sl(px, 1), 320);
        chk("co_y1", sl(py, 1), 240);
        chk("co_x0", sl(px, 0), 584);
        chk("co_spawn", sp, 1);
        chk("co_ready", rdy, 0);
        tick();
        tick();
        tick();
        chk("co_t3_ready", rdy, 0);
        chk("co_t3_x1", sl(px, 1), 332);
        chk("co_t3_x0", sl(px, 0), 596);
        ft = 1'b1;
        step();
        ft = 1'b0;
        chk("co_t4_ready", rdy, 1);
        chk("co_t4_x0", sl(px, 0), 600);

        // Asynchronous reset mid-flight, away from any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("arst_active", act, 0);
        chk("arst_x", px, 0);
        chk("arst_y", py, 0);
        chk("arst_ready", rdy, 0);
        chk("arst_spawn", sp, 0);
        chk("arst_expire", ex, 0);
        step();
        step();
        reset = 1'b0;
        #1;

        // COOLDOWN=0: fill the pool back to back, fifth request waits for a free slot.
        fv0 = 1'b1; ang0 = 4'd4;
        step();
        ang0 = 4'd0;
        chk("z_acc0_active", act0, 4'b0001);
        chk("z_acc0_ready", rdy0, 1);
        chk("z_acc0_spawn", sp0, 1);
        step();
        chk("z_acc1_active", act0, 4'b0011);
        step();
        chk("z_acc2_active", act0, 4'b0111);
        step();
        chk("z_full_active", act0, 4'b1111);
        chk("z_full_ready", rdy0, 0);
        chk("z_full_spawn", sp0, 1);
        step();
        chk("z_full_spawn_clr", sp0, 0);
        chk("z_full_hold", act0, 4'b1111);
        repeat (60) tick0();
        chk("z_t60_active", act0, 4'b1111);
        chk("z_t60_y0", sl(py0, 0), 0);
        chk("z_t60_x1", sl(px0, 1), 560);
        ft0 = 1'b1;
        step();
        ft0 = 1'b0;
        chk("z_t61_active", act0, 4'b1110);
        chk("z_t61_expire", ex0, 1);
        chk("z_t61_ready", rdy0, 1);
        chk("z_t61_y0", sl(py0, 0), 11'h7FC);
        step();
        fv0 = 1'b0;
        chk("z_acc4_active", act0, 4'b1111);
        chk("z_acc4_x0", sl(px0, 0), 320);
        chk("z_acc4_y0", sl(py0, 0), 240);
        chk("z_acc4_spawn", sp0, 1);
        chk("z_acc4_expire", ex0, 0);
        chk("z_acc4_x1", sl(px0, 1), 564);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
